mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port MEMORY between the cpu (port 0) and a DMA requester (port 1).
//  Sits between cpu/DMA address/data buses and MEMORY; drives cpu_rdy so the cpu stalls while DMA owns the bus.
//  Bounded DMA wait (MAX_WAIT) and bounded burst (BURST_MAX) keep both sides starvation-free.
// PARAMETERS
//  AW         16  address width
//  DW         8   data width
//  MAX_WAIT   4   cpu cycles a pending DMA request waits before grant; legal range >=1
//  BURST_MAX  8   max consecutive DMA-owned cycles before handing back to cpu; legal range >=1
// PORTS
//  CLK        in   1   clock, all state on posedge
//  R          in   1   reset, synchronous, active-low
//  cpu_addr   in   AW  cpu address
//  cpu_wdata  in   DW  cpu write data
//  cpu_we     in   1   cpu write enable
//  cpu_rdy    out  1   1 = cpu access performed this cycle; 0 = cpu must hold all state
//  cpu_rdata  out  DW  read data to cpu (= mem_rdata)
//  dma_req    in   1   DMA access request; addr/wdata/we valid while high
//  dma_addr   in   AW  DMA address
//  dma_wdata  in   DW  DMA write data
//  dma_we     in   1   DMA write enable
//  dma_gnt    out  1   DMA owns the bus this cycle
//  dma_ack    out  1   DMA access performed this cycle; dma_rdata valid
//  dma_rdata  out  DW  read data to DMA (= mem_rdata)
//  mem_addr   out  AW  to MEMORY.Address
//  mem_wdata  out  DW  to MEMORY.DataIn
//  mem_we     out  1   to MEMORY.WE
//  mem_rdata  in   DW  from MEMORY.DataOut (combinational read, write at posedge)
// BEHAVIOUR
//  - States: ST_CPU (cpu owns), ST_DMA (DMA owns). Registers: state, wait_cnt, burst_cnt.
//  - Reset (R==0 at posedge): state<=ST_CPU, wait_cnt<=0, burst_cnt<=0. While R==0, mem_we is forced 0
//    combinationally. Post-reset outputs: cpu_rdy=1, dma_gnt=0, dma_ack=0.
//  - Mux is combinational on registered state: ST_CPU -> mem_* = cpu_*; ST_DMA -> mem_* = dma_*.
//  - cpu_rdy = (state==ST_CPU); dma_gnt = (state==ST_DMA); dma_ack = dma_gnt & dma_req.
//  - mem_we = R & (ST_CPU ? cpu_we : dma_we & dma_req).
//  - ST_CPU: dma_req==0 -> wait_cnt<=0. dma_req==1 and wait_cnt<MAX_WAIT-1 -> wait_cnt++.
//    dma_req==1 and wait_cnt==MAX_WAIT-1 -> state<=ST_DMA, wait_cnt<=0, burst_cnt<=0.
//    First grant therefore occurs exactly MAX_WAIT cycles after dma_req rises.
//  - ST_DMA: dma_req==1 -> one access, burst_cnt++. If burst_cnt==BURST_MAX-1 -> state<=ST_CPU.
//    dma_req==0 -> no access (mem_we=0, dma_ack=0), state<=ST_CPU; this cycle is lost to both.
//  - Return to ST_CPU always clears burst_cnt. The cpu then owns >=MAX_WAIT cycles before the next grant.
//  - Counters never wrap: wait_cnt saturates at MAX_WAIT-1, burst_cnt resets on leaving ST_DMA.
//    Width of each counter = $clog2(limit+1).
//  - cpu inputs are ignored in ST_DMA. The cpu must re-present the same access when cpu_rdy returns.
//  - Reset mid-burst: the next cycle is ST_CPU with counters 0. No partial write occurs in the reset cycle.
//  - Latency: DMA read data is valid in the dma_ack cycle (zero wait states once granted).
// STRUCTURE
//  - Shared include bus_defs.vh: ST_CPU/ST_DMA encodings, default AW/DW.
//  - Single flat module; no sub-module warranted (two counters + 1-bit FSM + mux).
// TESTING
//  1. R=0 for 2 cycles with cpu_we=1, dma_req=1 -> mem_we=0 throughout. After release: cpu_rdy=1, dma_gnt=0.
//  2. MAX_WAIT=4, dma_req rises at cycle 0 -> cpu_rdy=1 cycles 0-3; dma_gnt=1, cpu_rdy=0 at cycle 4.
//  3. BURST_MAX=8, dma_req held high -> 8 consecutive dma_ack, then cpu_rdy=1 for exactly 4 cycles, repeat.
//  4. DMA write 0x5A to 0x0200, then cpu read 0x0200 -> cpu_rdata=0x5A. The cpu write to 0x0300 issued
//     during the grant lands only after cpu_rdy=1.
//  5. dma_req drops after 3 acks -> next cycle dma_ack=0, mem_we=0, then cpu_rdy=1.
//     A new request waits the full MAX_WAIT.
//  6. R=0 during the 5th burst cycle with dma_we=1 -> no write in that cycle. Next cycle cpu_rdy=1 and
//     wait_cnt=0, burst_cnt=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the cpu/DMA memory arbiter:
//     - arb_state_t : bus ownership state (cpu owns / DMA owns)
//     - DEF_AW/DEF_DW : default address and data widths
//     - cnt_width() : width of a counter that must hold 0..limit
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    // Default bus geometry shared by the interface and the arbiter.
    localparam int DEF_AW = 16;
    localparam int DEF_DW = 8;

    // Who drives the memory this cycle.
    typedef enum logic {
        ST_CPU = 1'b0,
        ST_DMA = 1'b1
    } arb_state_t;

    // Counter width able to represent every value from 0 up to 'limit'.
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the three buses that meet at the arbiter: the cpu port, the DMA
//   requester port and the single-port MEMORY.
//
//   cpu side : cpu_addr, cpu_wdata, cpu_we (to arbiter); cpu_rdy, cpu_rdata (back)
//   DMA side : dma_req, dma_addr, dma_wdata, dma_we (to arbiter);
//              dma_gnt, dma_ack, dma_rdata (back)
//   MEMORY   : mem_addr, mem_wdata, mem_we (to memory); mem_rdata (from memory,
//              combinational read)
//
//   Modports:
//     slave  - the arbiter's view
//     master - the surrounding system's view (cpu, DMA engine and memory)
// -----------------------------------------------------------------------------
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();

    // cpu port
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_we;
    logic          cpu_rdy;
    logic [DW-1:0] cpu_rdata;

    // DMA port
    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_we;
    logic          dma_gnt;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;

    // MEMORY port
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we,
        output cpu_rdy, cpu_rdata,
        input  dma_req, dma_addr, dma_wdata, dma_we,
        output dma_gnt, dma_ack, dma_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_we,
        input  cpu_rdy, cpu_rdata,
        output dma_req, dma_addr, dma_wdata, dma_we,
        input  dma_gnt, dma_ack, dma_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port MEMORY between the cpu and a DMA requester.
//   The cpu owns the bus by default; a DMA request that stays pending for
//   MAX_WAIT cycles is granted, and the DMA then keeps the bus for at most
//   BURST_MAX consecutive cycles before ownership returns to the cpu. While
//   the DMA owns the bus, cpu_rdy is low and the cpu holds its access.
//
// Parameters
//   AW, DW     address / data width (must match the interface instance)
//   MAX_WAIT   cycles a pending DMA request waits before grant (>= 1)
//   BURST_MAX  max consecutive DMA-owned cycles (>= 1)
//
// Ports
//   CLK  clock, all state on posedge
//   R    synchronous active-low reset
//   bus  mem_arbiter_if.slave : cpu, DMA and MEMORY buses
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic          CLK,
    input  logic          R,
    mem_arbiter_if.slave  bus
);

    localparam int WAIT_W  = cnt_width(MAX_WAIT);
    localparam int BURST_W = cnt_width(BURST_MAX);

    // Terminal counts: reaching these values ends the wait / the burst.
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_cnt_nxt;
    logic [BURST_W-1:0] r_burst_cnt;
    logic [BURST_W-1:0] w_burst_cnt_nxt;

    logic [AW-1:0]      w_mem_addr;
    logic [DW-1:0]      w_mem_wdata;
    logic               w_mem_we;
    logic               w_dma_owns;

    // -------------------------------------------------------------------------
    // State register (synchronous active-low reset)
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (!R) begin
            r_state     <= ST_CPU;
            r_wait_cnt  <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_burst_cnt_nxt = r_burst_cnt;

        unique case (r_state)
            ST_CPU: begin
                // The burst counter only runs while the DMA owns the bus.
                w_burst_cnt_nxt = '0;
                if (!bus.dma_req) begin
                    // A request must be continuously pending to accumulate wait.
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    // MAX_WAIT-th pending cycle: DMA owns the bus next cycle.
                    w_state_nxt    = ST_DMA;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end

            ST_DMA: begin
                w_wait_cnt_nxt = '0;
                if (!bus.dma_req) begin
                    // DMA went idle: hand the bus back; this cycle is unused.
                    w_state_nxt     = ST_CPU;
                    w_burst_cnt_nxt = '0;
                end else if (r_burst_cnt == BURST_LAST) begin
                    // Last access of the burst: cpu gets the bus back.
                    w_state_nxt     = ST_CPU;
                    w_burst_cnt_nxt = '0;
                end else begin
                    w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt     = ST_CPU;
                w_wait_cnt_nxt  = '0;
                w_burst_cnt_nxt = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Bus mux, driven from the registered state only
    // -------------------------------------------------------------------------
    assign w_dma_owns = (r_state == ST_DMA);

    always_comb begin
        w_mem_addr  = bus.cpu_addr;
        w_mem_wdata = bus.cpu_wdata;
        w_mem_we    = bus.cpu_we;
        if (w_dma_owns) begin
            w_mem_addr  = bus.dma_addr;
            w_mem_wdata = bus.dma_wdata;
            // An owned-but-idle DMA cycle must not write.
            w_mem_we    = bus.dma_we & bus.dma_req;
        end
    end

    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    // Reset gates the write strobe combinationally so the reset cycle itself
    // can never corrupt memory, even mid-burst.
    assign bus.mem_we    = R & w_mem_we;

    assign bus.cpu_rdy   = ~w_dma_owns;
    assign bus.dma_gnt   = w_dma_owns;
    assign bus.dma_ack   = w_dma_owns & bus.dma_req;

    // Memory read is combinational, so both requesters see it in the access cycle.
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dma_rdata = bus.mem_rdata;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter (MAX_WAIT=4, BURST_MAX=8, AW=16, DW=8).
//   A behavioural model (ownership flag, count of pending request cycles,
//   count of granted accesses, reference memory image) predicts every output
//   each cycle; directed scenarios pin the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW        = 16;
    localparam int DW        = 8;
    localparam int MAX_WAIT  = 4;
    localparam int BURST_MAX = 8;
    localparam int BOUND     = 40;

    logic CLK;
    logic R;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT),
        .BURST_MAX(BURST_MAX)
    ) dut (
        .CLK(CLK),
        .R  (R),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Environment memory: combinational read, write on posedge
    // -------------------------------------------------------------------------
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = DW'(i) ^ 8'hA5;
            ref_mem[i] = DW'(i) ^ 8'hA5;
        end
    end

    always @(posedge CLK) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    // -------------------------------------------------------------------------
    // Behavioural model + per-cycle compare (at negedge, inputs stable)
    // -------------------------------------------------------------------------
    bit m_valid    = 1'b0;  // DUT has seen at least one reset edge
    bit m_dma_owns = 1'b0;
    int m_waited   = 0;     // consecutive cycles a request has been pending
    int m_acks     = 0;     // accesses performed in the current grant

    always @(negedge CLK) begin
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_we;
        e_addr  = m_dma_owns ? bus.dma_addr  : bus.cpu_addr;
        e_wdata = m_dma_owns ? bus.dma_wdata : bus.cpu_wdata;
        e_we    = R && (m_dma_owns ? (bus.dma_we && bus.dma_req) : bus.cpu_we);

        if (m_valid) begin
            check("model_cpu_rdy",   32'(bus.cpu_rdy),   32'(!m_dma_owns));
            check("model_dma_gnt",   32'(bus.dma_gnt),   32'(m_dma_owns));
            check("model_dma_ack",   32'(bus.dma_ack),   32'(m_dma_owns && bus.dma_req));
            check("model_mem_we",    32'(bus.mem_we),    32'(e_we));
            check("model_mem_addr",  32'(bus.mem_addr),  32'(e_addr));
            check("model_mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
            check("model_cpu_rdata", 32'(bus.cpu_rdata), 32'(ref_mem[e_addr]));
            check("model_dma_rdata", 32'(bus.dma_rdata), 32'(ref_mem[e_addr]));
            if (e_we) ref_mem[e_addr] = e_wdata;
        end

        // Ownership rules for the next cycle.
        if (!R) begin
            m_valid    = 1'b1;
            m_dma_owns = 1'b0;
            m_waited   = 0;
            m_acks     = 0;
        end else if (!m_dma_owns) begin
            if (bus.dma_req) begin
                m_waited++;
                if (m_waited == MAX_WAIT) begin
                    m_dma_owns = 1'b1;
                    m_waited   = 0;
                    m_acks     = 0;
                end
            end else begin
                m_waited = 0;
            end
        end else begin
            if (bus.dma_req) begin
                m_acks++;
                if (m_acks == BURST_MAX) m_dma_owns = 1'b0;
            end else begin
                m_dma_owns = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_cpu(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_we    = we;
    endtask

    task automatic set_dma(input logic req, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic we);
        bus.dma_req   = req;
        bus.dma_addr  = a;
        bus.dma_wdata = d;
        bus.dma_we    = we;
    endtask

    // Cycles from now (already settled) until dma_gnt, bounded.
    task automatic measure_grant(input string name, input int exp_cycles);
        int k;
        k = 0;
        while (!bus.dma_gnt && k < BOUND) begin
            tick();
            settle();
            k++;
        end
        check(name, 32'(k), 32'(exp_cycles));
    endtask

    task automatic wait_ack(input string name);
        int k;
        k = 0;
        while (!bus.dma_ack && k < BOUND) begin
            tick();
            settle();
            k++;
        end
        check(name, 32'(bus.dma_ack), 32'd1);
    endtask

    task automatic wait_cpu(input string name);
        int k;
        k = 0;
        while (!bus.cpu_rdy && k < BOUND) begin
            tick();
            settle();
            k++;
        end
        check(name, 32'(bus.cpu_rdy), 32'd1);
    endtask

    // Counts acks while granted, then cpu cycles until the next grant.
    task automatic measure_burst(input string name_acks, input string name_cpu,
                                 input int exp_acks, input int exp_cpu);
        int n;
        int m;
        n = 0;
        while (bus.dma_gnt && n < BOUND) begin
            if (bus.dma_ack) n++;
            tick();
            settle();
        end
        check(name_acks, 32'(n), 32'(exp_acks));
        m = 0;
        while (bus.cpu_rdy && m < BOUND) begin
            m++;
            tick();
            settle();
        end
        check(name_cpu, 32'(m), 32'(exp_cpu));
    endtask

    // -------------------------------------------------------------------------
    // Directed scenarios, then randomized traffic
    // -------------------------------------------------------------------------
    initial begin
        // 1: reset held two cycles with both sides trying to write.
        R = 1'b0;
        set_cpu(16'h0010, 8'h11, 1'b1);
        set_dma(1'b1, 16'h0020, 8'h22, 1'b1);
        settle();
        check("t1_reset_we_c0", 32'(bus.mem_we), 32'd0);
        tick();
        check("t1_reset_we_c1", 32'(bus.mem_we), 32'd0);
        tick();
        R = 1'b1;
        set_cpu(16'h0000, 8'h00, 1'b0);
        set_dma(1'b0, 16'h0000, 8'h00, 1'b0);
        settle();
        check("t1_post_cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
        check("t1_post_dma_gnt", 32'(bus.dma_gnt), 32'd0);
        check("t1_mem_0010_kept", 32'(mem[16'h0010]), 32'(8'h10 ^ 8'hA5));

        // 2: request rises at cycle 0, grant at cycle 4.
        tick();
        set_dma(1'b1, 16'h0040, 8'h00, 1'b0);
        settle();
        measure_grant("t2_grant_latency", 4);
        check("t2_cpu_rdy_at_grant", 32'(bus.cpu_rdy), 32'd0);

        // 3: request held high -> 8 acks, 4 cpu cycles, repeating.
        measure_burst("t3_burst_acks_a", "t3_cpu_cycles_a", 8, 4);
        measure_burst("t3_burst_acks_b", "t3_cpu_cycles_b", 8, 4);

        // 4: DMA write then cpu read; cpu write held during the grant.
        set_dma(1'b0, 16'h0000, 8'h00, 1'b0);
        tick();
        settle();
        wait_cpu("t4_idle_cpu");
        set_dma(1'b1, 16'h0200, 8'h5A, 1'b1);
        settle();
        wait_ack("t4_dma_ack");
        check("t4_dma_we",   32'(bus.mem_we),   32'd1);
        check("t4_dma_addr", 32'(bus.mem_addr), 32'h0200);
        set_cpu(16'h0300, 8'h77, 1'b1);
        tick();
        set_dma(1'b0, 16'h0200, 8'h5A, 1'b1);
        settle();
        check("t4_lost_ack",    32'(bus.dma_ack), 32'd0);
        check("t4_lost_we",     32'(bus.mem_we),  32'd0);
        check("t4_lost_rdy",    32'(bus.cpu_rdy), 32'd0);
        check("t4_0300_unset",  32'(mem[16'h0300]), 32'h00A5);
        tick();
        settle();
        check("t4_cpu_back",    32'(bus.cpu_rdy), 32'd1);
        check("t4_cpu_we",      32'(bus.mem_we),  32'd1);
        tick();
        set_cpu(16'h0200, 8'h00, 1'b0);
        settle();
        check("t4_cpu_rdata",   32'(bus.cpu_rdata), 32'h005A);
        check("t4_0300_landed", 32'(mem[16'h0300]), 32'h0077);

        // 5: request drops after 3 acks.
        set_dma(1'b1, 16'h0100, 8'h33, 1'b1);
        wait_ack("t5_ack1");
        tick();
        tick();
        tick();
        set_dma(1'b0, 16'h0100, 8'h33, 1'b1);
        settle();
        check("t5_drop_ack", 32'(bus.dma_ack), 32'd0);
        check("t5_drop_we",  32'(bus.mem_we),  32'd0);
        check("t5_drop_gnt", 32'(bus.dma_gnt), 32'd1);
        tick();
        settle();
        check("t5_cpu_back", 32'(bus.cpu_rdy), 32'd1);
        set_dma(1'b1, 16'h0100, 8'h00, 1'b0);
        settle();
        measure_grant("t5_rewait", 4);

        // 6: reset during the 5th burst cycle with a write pending.
        set_dma(1'b0, 16'h0000, 8'h00, 1'b0);
        tick();
        settle();
        wait_cpu("t6_idle_cpu");
        set_dma(1'b1, 16'h0400, 8'hC3, 1'b1);
        settle();
        measure_grant("t6_grant_latency", 4);
        for (int j = 0; j < 4; j++) begin
            bus.dma_addr = 16'h0400 + 16'(j);
            tick();
        end
        bus.dma_addr = 16'h0404;
        R = 1'b0;
        settle();
        check("t6_reset_we", 32'(bus.mem_we), 32'd0);
        tick();
        R = 1'b1;
        settle();
        check("t6_cpu_rdy",   32'(bus.cpu_rdy),   32'd1);
        check("t6_dma_gnt",   32'(bus.dma_gnt),   32'd0);
        check("t6_0404_kept", 32'(mem[16'h0404]), 32'h00A1);
        check("t6_0403_done", 32'(mem[16'h0403]), 32'h00C3);
        measure_grant("t6_wait_cleared", 4);
        measure_burst("t6_burst_cleared", "t6_cpu_cycles", 8, 4);

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            tick();
            R = ($urandom_range(0, 199) != 0);
            set_cpu(16'($urandom_range(0, 31)), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) bus.dma_req = ~bus.dma_req;
            bus.dma_addr  = 16'($urandom_range(0, 31));
            bus.dma_wdata = 8'($urandom);
            bus.dma_we    = 1'($urandom);
        end
        tick();
        R = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_mem_arbiter
